// File: rtl/spr_buf_reader.sv
// Scanout side of the 128x9 sprite line buffer: reads one ring slot per dot, presents the
// decoded pixel to the mixer and (optionally) zeroes the slot so the renderer can reuse it.
module spr_buf_reader #(
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 7,
    parameter int CLEAR_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              line_start,
    input  logic              dot_ce,
    input  logic [8:0]        wr_x,
    output logic [ADDR_W-1:0] adb,
    output logic [8:0]        dinb,
    output logic              wreb,
    output logic              ceb,
    output logic              oceb,
    input  logic [8:0]        doutb,
    output logic              pix_valid,
    output logic [7:0]        pix_x,
    output logic [3:0]        pix_color,
    output logic [2:0]        pix_pal,
    output logic [1:0]        pix_prio,
    output logic              busy,
    output logic              underrun
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RD,
        CAP
    } state_t;

    localparam logic [7:0] X_LAST = 8'(LINE_W - 1);

    state_t     state, state_nxt;
    logic [7:0] x, x_nxt;
    logic       not_ready;

    // Pixel x is only final once the renderer's progress counter has moved past it.
    assign not_ready = ({1'b0, x} >= wr_x);

    assign dinb = '0;
    assign oceb = 1'b1;
    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            x     <= '0;
        end else begin
            state <= state_nxt;
            x     <= x_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        adb       = '0;
        ceb       = 1'b0;
        wreb      = 1'b0;

        case (state)
            IDLE: begin
                if (line_start) begin
                    state_nxt = WAIT;
                    x_nxt     = '0;
                end
            end
            WAIT: begin
                if (line_start) begin
                    x_nxt = '0;
                end else if (dot_ce) begin
                    state_nxt = RD;
                end
            end
            RD: begin
                adb = x[ADDR_W-1:0];
                ceb = 1'b1;
                // An abort here drops the pixel before its data ever returns.
                if (line_start) begin
                    state_nxt = WAIT;
                    x_nxt     = '0;
                end else begin
                    state_nxt = CAP;
                end
            end
            CAP: begin
                // Clear the slot in the cycle its read data returns; the read has already
                // completed, so the port never reads and writes one slot together.
                if (CLEAR_EN != 0) begin
                    adb  = x[ADDR_W-1:0];
                    ceb  = 1'b1;
                    wreb = 1'b1;
                end
                if (line_start) begin
                    state_nxt = WAIT;
                    x_nxt     = '0;
                end else if (x == X_LAST) begin
                    state_nxt = IDLE;
                    x_nxt     = '0;
                end else begin
                    state_nxt = WAIT;
                    x_nxt     = x + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                x_nxt     = '0;
            end
        endcase

        // Reset silences the RAM port in the very cycle it is sampled.
        if (reset) begin
            adb  = '0;
            ceb  = 1'b0;
            wreb = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_color <= '0;
            pix_pal   <= '0;
            pix_prio  <= '0;
            underrun  <= 1'b0;
        end else begin
            pix_valid <= (state == CAP);
            if (state == CAP) begin
                pix_x     <= x;
                pix_prio  <= doutb[8:7];
                pix_pal   <= doutb[6:4];
                pix_color <= not_ready ? 4'd0 : doutb[3:0];
            end
            if (line_start) begin
                underrun <= 1'b0;
            end else if (state == CAP && not_ready) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spr_buf_reader.sv
// Bench for spr_buf_reader: behavioural RAM models, a pixel scoreboard, a table of
// single-pixel vectors and hand sequences for aborts, reset and full-line scanout.
module tb_spr_buf_reader;

    typedef struct {
        int         x;
        logic [8:0] data;
        logic [8:0] wr_x;
        logic [1:0] prio;
        logic [2:0] pal;
        logic [3:0] color;
        logic       ur;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [1:0] prio;
        logic [2:0] pal;
        logic [3:0] color;
        int         cyc;
    } pix_t;

    logic       clk = 1'b0;
    logic       reset, line_start, dot_ce;
    logic [8:0] wr_x;

    logic [6:0] adb0, adb1;
    logic [8:0] dinb0, dinb1, doutb0, doutb1;
    logic       wreb0, wreb1, ceb0, ceb1, oceb0, oceb1;
    logic       pix_valid0, pix_valid1, busy0, busy1, underrun0, underrun1;
    logic [7:0] pix_x0, pix_x1;
    logic [3:0] pix_color0, pix_color1;
    logic [2:0] pix_pal0, pix_pal1;
    logic [1:0] pix_prio0, pix_prio1;

    logic [8:0] ram0[128];
    logic [8:0] ram1[128];
    logic [8:0] ram1_init[128];
    logic [8:0] g0[128];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pix0 = 0, n_clr0 = 0, n_slot0 = 0, n_pix1 = 0, n_wr1 = 0;
    logic [7:0] mx;
    pix_t exp_q[$];
    vec_t vt[7];

    spr_buf_reader #(.LINE_W(256), .ADDR_W(7), .CLEAR_EN(1)) u_dut (
        .clk(clk), .reset(reset), .line_start(line_start), .dot_ce(dot_ce), .wr_x(wr_x),
        .adb(adb0), .dinb(dinb0), .wreb(wreb0), .ceb(ceb0), .oceb(oceb0), .doutb(doutb0),
        .pix_valid(pix_valid0), .pix_x(pix_x0), .pix_color(pix_color0), .pix_pal(pix_pal0),
        .pix_prio(pix_prio0), .busy(busy0), .underrun(underrun0)
    );

    spr_buf_reader #(.LINE_W(256), .ADDR_W(7), .CLEAR_EN(0)) u_ro (
        .clk(clk), .reset(reset), .line_start(line_start), .dot_ce(dot_ce), .wr_x(wr_x),
        .adb(adb1), .dinb(dinb1), .wreb(wreb1), .ceb(ceb1), .oceb(oceb1), .doutb(doutb1),
        .pix_valid(pix_valid1), .pix_x(pix_x1), .pix_color(pix_color1), .pix_pal(pix_pal1),
        .pix_prio(pix_prio1), .busy(busy1), .underrun(underrun1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Port B of each buffer: one-cycle read latency, write when wreb is set.
    always @(posedge clk) begin
        if (ceb0) begin
            if (wreb0) ram0[adb0] <= dinb0;
            else       doutb0 <= ram0[adb0];
        end
        if (ceb1) begin
            if (wreb1) ram1[adb1] <= dinb1;
            else       doutb1 <= ram1[adb1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        pix_t e;
        if (pix_valid0 === 1'b1) begin
            n_pix0++;
            if (exp_q.size() == 0) begin
                check("unexpected pix_valid", 32'(pix_valid0), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pix_x", 32'(pix_x0), 32'(e.x));
                check("pix fields", 32'({pix_prio0, pix_pal0, pix_color0}),
                      32'({e.prio, e.pal, e.color}));
                check("pix latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (ceb0 === 1'b1 && wreb0 === 1'b1) begin
            n_clr0++;
            if (adb0 == 7'd0) n_slot0++;
        end
        if (pix_valid1 === 1'b1) n_pix1++;
        if (wreb1 === 1'b1) n_wr1++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mx = '0;
    endtask

    task automatic clear_ram0();
        for (int i = 0; i < 128; i++) begin
            ram0[i] = '0;
            g0[i]   = '0;
        end
    endtask

    task automatic pulse_line_start();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        mx = '0;
    endtask

    // Model of one presented pixel: slot content, forced transparent when not yet rendered.
    task automatic push_dot();
        pix_t       e;
        logic [8:0] d;
        logic [6:0] s;
        s       = mx[6:0];
        d       = g0[s];
        e.x     = mx;
        e.prio  = d[8:7];
        e.pal   = d[6:4];
        e.color = ({1'b0, mx} >= wr_x) ? 4'd0 : d[3:0];
        e.cyc   = cyc + 3;
        g0[s]   = '0;
        exp_q.push_back(e);
        mx = mx + 8'd1;
    endtask

    task automatic drive_dot();
        push_dot();
        dot_ce = 1'b1;
        tick();
        dot_ce = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        int base, base_clr, base_s0, base_p1, base_w1, cnt;
        logic [6:0] s;

        vt[0] = '{5,   9'h1A3, 9'd256, 2'd3, 3'd2, 4'h3, 1'b0};
        vt[1] = '{127, 9'h055, 9'd200, 2'd0, 3'd5, 4'h5, 1'b0};
        vt[2] = '{0,   9'h1FF, 9'd256, 2'd3, 3'd7, 4'hF, 1'b0};
        vt[3] = '{9,   9'h0C7, 9'd10,  2'd1, 3'd4, 4'h7, 1'b0};
        vt[4] = '{3,   9'h12A, 9'd0,   2'd2, 3'd2, 4'h0, 1'b1};
        vt[5] = '{12,  9'h0FF, 9'd10,  2'd1, 3'd7, 4'h0, 1'b1};
        vt[6] = '{9,   9'h0C7, 9'd9,   2'd1, 3'd4, 4'h0, 1'b1};

        reset = 1'b1;
        line_start = 1'b0;
        dot_ce = 1'b0;
        wr_x = '0;
        mx = '0;
        clear_ram0();
        for (int i = 0; i < 128; i++) begin
            ram1[i]      = 9'((i * 29 + 5) % 512);
            ram1_init[i] = 9'((i * 29 + 5) % 512);
        end
        tick();
        tick();

        check("reset ceb", 32'(ceb0), 32'd0);
        check("reset wreb", 32'(wreb0), 32'd0);
        check("reset oceb", 32'(oceb0), 32'd1);
        check("reset dinb", 32'(dinb0), 32'd0);
        check("reset busy", 32'(busy0), 32'd0);
        check("reset pix_valid", 32'(pix_valid0), 32'd0);
        check("reset pix regs", 32'({pix_x0, pix_prio0, pix_pal0, pix_color0}), 32'd0);
        check("reset underrun", 32'(underrun0), 32'd0);
        reset = 1'b0;
        tick();
        check("idle busy", 32'(busy0), 32'd0);
        check("idle ceb", 32'(ceb0), 32'd0);

        // Table: one preloaded slot, scan up to it, compare held pixel and status.
        for (int r = 0; r < 7; r++) begin
            do_reset();
            clear_ram0();
            s = 7'(vt[r].x);
            ram0[s] = vt[r].data;
            g0[s]   = vt[r].data;
            wr_x = vt[r].wr_x;
            pulse_line_start();
            for (int i = 0; i <= vt[r].x; i++) drive_dot();
            check("vec pix_x", 32'(pix_x0), 32'(vt[r].x));
            check("vec prio", 32'(pix_prio0), 32'(vt[r].prio));
            check("vec pal", 32'(pix_pal0), 32'(vt[r].pal));
            check("vec color", 32'(pix_color0), 32'(vt[r].color));
            check("vec underrun", 32'(underrun0), 32'(vt[r].ur));
            check("vec slot cleared", 32'(ram0[s]), 32'd0);
            check("vec busy", 32'(busy0), 32'd1);
        end

        // Underrun is sticky across later good pixels until line_start.
        for (int i = 0; i < 5; i++) tick();
        check("underrun sticky idle", 32'(underrun0), 32'd1);
        wr_x = 9'd256;
        drive_dot();
        check("underrun sticky good pixel", 32'(underrun0), 32'd1);
        pulse_line_start();
        check("underrun cleared by line_start", 32'(underrun0), 32'd0);

        // Full line with the renderer refilling each slot for x+128 after it is cleared.
        do_reset();
        clear_ram0();
        for (int i = 0; i < 128; i++) begin
            ram0[i] = 9'((i * 53 + 17) % 511 + 1);
            g0[i]   = 9'((i * 53 + 17) % 511 + 1);
        end
        wr_x = 9'd256;
        base = n_pix0;
        base_clr = n_clr0;
        base_s0 = n_slot0;
        base_p1 = n_pix1;
        base_w1 = n_wr1;
        pulse_line_start();
        for (int i = 0; i < 256; i++) begin
            if (i >= 1 && i <= 128) begin
                ram0[i-1] = 9'(((i + 127) * 53 + 17) % 511 + 1);
                g0[i-1]   = 9'(((i + 127) * 53 + 17) % 511 + 1);
            end
            if (i == 255) check("busy before last dot", 32'(busy0), 32'd1);
            drive_dot();
        end
        check("line pixel count", 32'(n_pix0 - base), 32'd256);
        check("line last pix_x", 32'(pix_x0), 32'd255);
        check("line busy falls", 32'(busy0), 32'd0);
        check("line clear writes", 32'(n_clr0 - base_clr), 32'd256);
        check("line slot0 writes", 32'(n_slot0 - base_s0), 32'd2);
        cnt = 0;
        for (int i = 0; i < 128; i++) if (ram0[i] != 9'd0) cnt++;
        check("line all slots zero", 32'(cnt), 32'd0);
        check("ro pixel count", 32'(n_pix1 - base_p1), 32'd256);
        check("ro wreb count", 32'(n_wr1 - base_w1), 32'd0);
        cnt = 0;
        for (int i = 0; i < 128; i++) if (ram1[i] != ram1_init[i]) cnt++;
        check("ro ram unchanged", 32'(cnt), 32'd0);

        // dot_ce in IDLE is ignored.
        do_reset();
        clear_ram0();
        wr_x = 9'd256;
        base = n_pix0;
        dot_ce = 1'b1;
        tick();
        dot_ce = 1'b0;
        tick();
        tick();
        tick();
        check("idle dot busy", 32'(busy0), 32'd0);
        check("idle dot no pixel", 32'(n_pix0 - base), 32'd0);

        // line_start in CAP at x=40: pixel 40 still presented and cleared.
        ram0[40] = 9'h0E6;
        g0[40]   = 9'h0E6;
        ram0[0]  = 9'h111;
        g0[0]    = 9'h111;
        pulse_line_start();
        for (int i = 0; i < 40; i++) drive_dot();
        push_dot();
        dot_ce = 1'b1;
        tick();
        dot_ce = 1'b0;
        tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        mx = '0;
        tick();
        tick();
        check("cap abort pix_x", 32'(pix_x0), 32'd40);
        check("cap abort slot cleared", 32'(ram0[40]), 32'd0);
        ram0[0] = 9'h122;
        g0[0]   = 9'h122;
        drive_dot();
        check("cap abort restart x", 32'(pix_x0), 32'd0);

        // line_start during RD: no pixel, no clear.
        ram0[1] = 9'h0B5;
        g0[1]   = 9'h0B5;
        dot_ce = 1'b1;
        tick();
        dot_ce = 1'b0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        mx = '0;
        tick();
        tick();
        tick();
        check("rd abort slot kept", 32'(ram0[1]), 32'h0B5);
        check("rd abort no pixel", 32'(pix_x0), 32'd0);
        ram0[0] = 9'h0C2;
        g0[0]   = 9'h0C2;
        drive_dot();
        drive_dot();
        check("rd abort x1 pix_x", 32'(pix_x0), 32'd1);
        check("rd abort x1 fields", 32'({pix_prio0, pix_pal0, pix_color0}), 32'({2'd1, 3'd3, 4'h5}));

        // dot_ce repeated while in RD is ignored.
        base = n_pix0;
        push_dot();
        dot_ce = 1'b1;
        tick();
        tick();
        dot_ce = 1'b0;
        tick();
        tick();
        tick();
        check("rd dot ignored count", 32'(n_pix0 - base), 32'd1);
        drive_dot();
        check("after rd dot pix_x", 32'(pix_x0), 32'd3);

        // Reset during RD: port released in the reset cycle, restart at x=0.
        ram0[0] = 9'h1C9;
        g0[0]   = 9'h1C9;
        dot_ce = 1'b1;
        tick();
        dot_ce = 1'b0;
        check("rd ceb", 32'(ceb0), 32'd1);
        check("rd wreb", 32'(wreb0), 32'd0);
        check("rd adb", 32'(adb0), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        check("reset-in-rd ceb same cycle", 32'(ceb0), 32'd0);
        check("reset-in-rd wreb same cycle", 32'(wreb0), 32'd0);
        tick();
        check("reset-in-rd busy", 32'(busy0), 32'd0);
        check("reset-in-rd pix_valid", 32'(pix_valid0), 32'd0);
        check("reset-in-rd ceb", 32'(ceb0), 32'd0);
        reset = 1'b0;
        mx = '0;
        tick();
        check("reset-in-rd idle ceb", 32'(ceb0), 32'd0);
        pulse_line_start();
        drive_dot();
        check("restart pix_x", 32'(pix_x0), 32'd0);
        check("restart fields", 32'({pix_prio0, pix_pal0, pix_color0}), 32'({2'd3, 3'd4, 4'h9}));

        tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
